// File: rtl/iter_shift_if.sv
// Start/busy/done handshake bundle for the iterative shift sequencer.
// The master issues shift requests and the slave (the sequencer) returns status and the result.
interface iter_shift_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic               err;
    logic [WIDTH-1:0]   dout;

    modport master (output start, op, din, shamt, input busy, done, err, dout);
    modport slave  (input start, op, din, shamt, output busy, done, err, dout);
endinterface

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer built from one shift-by-2 stage and one shift-by-1 stage.
// Each cycle consumes two bits of the remaining amount, and one bit on the final odd step.
module iter_shift_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    iter_shift_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t             state, state_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [SHAMT_W-1:0] rem, rem_n;
    logic [1:0]         op_q, op_n;
    logic               err_q, err_n;

    logic [WIDTH-1:0]   sh2, sh1;
    logic               fill;

    // Both stages are always computed; the remaining count selects which one is taken.
    assign fill = (op_q == OP_SRA) ? acc[WIDTH-1] : 1'b0;

    always_comb begin
        sh2 = acc;
        sh1 = acc;
        case (op_q)
            OP_SLL: begin
                sh2 = {acc[WIDTH-3:0], 2'b00};
                sh1 = {acc[WIDTH-2:0], 1'b0};
            end
            OP_SRL, OP_SRA: begin
                sh2 = {{2{fill}}, acc[WIDTH-1:2]};
                sh1 = {fill, acc[WIDTH-1:1]};
            end
            default: begin
                sh2 = acc;
                sh1 = acc;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        op_n    = op_q;
        err_n   = err_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    acc_n = bus.din;
                    rem_n = bus.shamt;
                    op_n  = bus.op;
                    if (bus.op == OP_RSV) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else if (bus.shamt == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (rem >= SHAMT_W'(2)) begin
                    acc_n = sh2;
                    rem_n = rem - SHAMT_W'(2);
                end else if (rem == SHAMT_W'(1)) begin
                    acc_n = sh1;
                    rem_n = '0;
                end else begin
                    rem_n = '0;
                end
                if (rem_n == '0) state_n = S_DONE;
            end
            S_DONE: begin
                err_n   = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= OP_SLL;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            rem   <= rem_n;
            op_q  <= op_n;
            err_q <= err_n;
        end
    end

    assign bus.busy = (state == S_SHIFT);
    assign bus.done = (state == S_DONE);
    assign bus.err  = err_q;
    assign bus.dout = acc;
endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: vector table plus hand-written ignore-start and mid-shift reset sequences.
module tb_iter_shift_ctrl;
    localparam int W  = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iter_shift_if #(.WIDTH(W), .SHAMT_W(SW)) sif();
    iter_shift_ctrl #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  din;
        logic [SW-1:0] shamt;
        logic [W-1:0]  exp_dout;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] din, input logic [SW-1:0] shamt);
        sif.start = 1'b1;
        sif.op    = op;
        sif.din   = din;
        sif.shamt = shamt;
    endtask

    // Caller is positioned at a negedge in IDLE; drive, accept on the next posedge, then time to done.
    task automatic run_op(input vec_t v, input string name);
        int  n;
        int  busy_n;
        bit  seen;
        logic [W-1:0] res;
        drive(v.op, v.din, v.shamt);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.din   = ~v.din;
        sif.shamt = ~v.shamt;
        n = 0; busy_n = 0; seen = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (sif.busy) busy_n++;
            if (sif.done) seen = 1;
        end
        res = sif.dout;
        chk({name, " latency"}, 32'(n), 32'(v.exp_lat));
        chk({name, " dout"}, res, v.exp_dout);
        chk({name, " err"}, 32'(sif.err), 32'(v.exp_err));
        chk({name, " busy_cycles"}, 32'(busy_n), 32'(v.exp_lat - 1));
        @(negedge clk);
        chk({name, " post done/err/busy"}, {29'd0, sif.done, sif.err, sif.busy}, 32'd0);
        chk({name, " dout held"}, sif.dout, v.exp_dout);
    endtask

    initial begin
        int  n;
        int  done_n;
        bit  seen;
        vec_t v;

        vt[0]  = '{2'b00, 32'h0000_0001,  5'd5,  32'h0000_0020, 1'b0, 4};
        vt[1]  = '{2'b10, 32'h8000_0000,  5'd31, 32'hFFFF_FFFF, 1'b0, 17};
        vt[2]  = '{2'b01, 32'h8000_0000,  5'd31, 32'h0000_0001, 1'b0, 17};
        vt[3]  = '{2'b01, 32'hDEAD_BEEF,  5'd0,  32'hDEAD_BEEF, 1'b0, 1};
        vt[4]  = '{2'b11, 32'h1234_5678,  5'd7,  32'h1234_5678, 1'b1, 1};
        vt[5]  = '{2'b10, 32'hF000_0000,  5'd4,  32'hFF00_0000, 1'b0, 3};
        vt[6]  = '{2'b01, 32'hF000_0000,  5'd4,  32'h0F00_0000, 1'b0, 3};
        vt[7]  = '{2'b00, 32'hFFFF_FFFF,  5'd31, 32'h8000_0000, 1'b0, 17};
        vt[8]  = '{2'b10, 32'h7FFF_FFFF,  5'd30, 32'h0000_0001, 1'b0, 16};
        vt[9]  = '{2'b00, 32'h1234_5678,  5'd1,  32'h2468_ACF0, 1'b0, 2};
        vt[10] = '{2'b10, 32'h8000_0001,  5'd3,  32'hF000_0000, 1'b0, 3};

        sif.start = 1'b0;
        sif.op    = 2'b00;
        sif.din   = '0;
        sif.shamt = '0;

        #12;
        chk("reset busy/done/err", {29'd0, sif.busy, sif.done, sif.err}, 32'd0);
        chk("reset dout", sif.dout, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_op(vt[i], $sformatf("vec%0d", i));
        end

        // SLL 0x3 by 10 with a competing start in busy cycle 2.
        @(negedge clk);
        drive(2'b00, 32'h0000_0003, 5'd10);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                chk("ignore mid dout", sif.dout, 32'h0000_000C);
                drive(2'b00, 32'hFFFF_FFFF, 5'd0);
            end
            if (n == 3) sif.start = 1'b0;
            if (sif.done) seen = 1;
        end
        chk("ignore latency", 32'(n), 32'd6);
        chk("ignore dout", sif.dout, 32'h0000_0C00);
        @(negedge clk);
        v = '{2'b01, 32'h0000_0100, 5'd2, 32'h0000_0040, 1'b0, 2};
        run_op(v, "after_ignore");

        // Asynchronous reset between edges during a long SRA.
        @(negedge clk);
        drive(2'b10, 32'h8000_0000, 5'd31);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 32'(sif.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy/done/err", {29'd0, sif.busy, sif.done, sif.err}, 32'd0);
        chk("async rst dout", sif.dout, 32'd0);
        done_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (sif.done || sif.busy) done_n++;
        end
        chk("no done during reset", 32'(done_n), 32'd0);
        rst_n = 1'b1;
        v = '{2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 2};
        run_op(v, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
